sync_edge_filt: RTL and testbench

SYNC_EDGE_FILT -- requirements
Module: sync_edge_filt

---
 rtl/sync_edge_filt_if.sv | 23 ++
 rtl/sync_edge_filt.sv | 91 +++++++++
 tb/tb_sync_edge_filt.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sync_edge_filt_if.sv
// Bundle of the per-channel level inputs, clears and filtered edge outputs
// shared between sync_edge_filt and its consumer.
interface sync_edge_filt_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sig_nsyn;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] sig_syn;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt_flag;
    logic             changed;

    modport master (
        output sig_nsyn, clr,
        input  sig_syn, rise, fall, evt_flag, changed
    );

    modport slave (
        input  sig_nsyn, clr,
        output sig_syn, rise, fall, evt_flag, changed
    );
endinterface

// File: rtl/sync_edge_filt.sv
// Multi-channel async level synchroniser with persistence filter, registered
// rise/fall pulses and sticky per-channel event flags.
module sync_edge_filt_lane #(
    parameter int STAGES = 3,
    parameter int FILT   = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    input  logic i_clr,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall,
    output logic o_evt
);
    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    logic [STAGES-1:0] r_sync;
    logic [CW-1:0]     r_cnt;
    logic              r_lvl, r_rise, r_fall, r_evt;
    logic              w_s, w_diff, w_acc;

    assign w_s    = r_sync[STAGES-1];
    assign w_diff = (w_s != r_lvl);
    assign w_acc  = w_diff && (r_cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_lvl  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_evt  <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_rise <= w_acc &  w_s;
            r_fall <= w_acc & ~w_s;
            // Any return to the accepted level drops the partial count.
            if (!w_diff || w_acc) r_cnt <= '0;
            else                  r_cnt <= r_cnt + CW'(1);
            if (w_acc) r_lvl <= w_s;
            // Set beats clear when both land on the same edge.
            if (w_acc)      r_evt <= 1'b1;
            else if (i_clr) r_evt <= 1'b0;
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_evt  = r_evt;
endmodule

module sync_edge_filt #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 3,
    parameter int FILT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    sync_edge_filt_if.slave  bus
);
    logic [WIDTH-1:0] w_in, w_clr, w_lvl, w_rise, w_fall, w_evt;

    assign w_in  = bus.sig_nsyn;
    assign w_clr = bus.clr;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        sync_edge_filt_lane #(
            .STAGES (STAGES),
            .FILT   (FILT)
        ) u_lane (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_async (w_in[g]),
            .i_clr   (w_clr[g]),
            .o_lvl   (w_lvl[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g]),
            .o_evt   (w_evt[g])
        );
    end

    assign bus.sig_syn  = w_lvl;
    assign bus.rise     = w_rise;
    assign bus.fall     = w_fall;
    assign bus.evt_flag = w_evt;
    assign bus.changed  = |(w_rise | w_fall);
endmodule

// File: tb/tb_sync_edge_filt.sv
// Directed bench for sync_edge_filt at WIDTH=4, STAGES=3, FILT=4: latency,
// glitch rejection, count restart, clear/set priority and reset behaviour.
module tb_sync_edge_filt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    sync_edge_filt_if #(.WIDTH(4)) bus ();

    sync_edge_filt #(.WIDTH(4), .STAGES(3), .FILT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_syn, input logic [3:0] e_rise,
                           input logic [3:0] e_fall, input logic [3:0] e_evt);
        chk({tag, ".sig_syn"},  32'(bus.sig_syn),  32'(e_syn));
        chk({tag, ".rise"},     32'(bus.rise),     32'(e_rise));
        chk({tag, ".fall"},     32'(bus.fall),     32'(e_fall));
        chk({tag, ".evt_flag"}, 32'(bus.evt_flag), 32'(e_evt));
        chk({tag, ".changed"},  32'(bus.changed),  32'(|(e_rise | e_fall)));
    endtask

    initial begin
        bus.sig_nsyn = 4'b0000;
        bus.clr      = 4'b0000;

        // Reset held two edges, then idle with all inputs low.
        rst = 1'b1;
        tick(); tick();
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk_all("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // ch0 rises: first sampled at edge 1, accepted at edge STAGES+FILT = 7.
        bus.sig_nsyn = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_all("ch0_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        tick();
        chk_all("ch0_rise", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        tick();
        chk_all("ch0_after", 4'b0001, 4'b0000, 4'b0000, 4'b0001);

        // ch1 glitch: high 3 samples only, never accepted.
        bus.sig_nsyn = 4'b0011;
        for (int i = 1; i <= 13; i++) begin
            if (i == 4) bus.sig_nsyn = 4'b0001;
            tick();
            chk_all("ch1_glitch", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        end

        // ch2: 3 high, 1 low, then held; count restarts so acceptance is at edge 11.
        bus.sig_nsyn = 4'b0101;
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) bus.sig_nsyn = 4'b0001;
            if (i == 5) bus.sig_nsyn = 4'b0101;
            tick();
            chk_all("ch2_restart", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        end
        tick();
        chk_all("ch2_rise", 4'b0101, 4'b0100, 4'b0000, 4'b0101);
        tick();
        chk_all("ch2_after", 4'b0101, 4'b0000, 4'b0000, 4'b0101);

        // ch0 falls with clr[0] on the same edge: set wins; clr next edge clears.
        bus.sig_nsyn = 4'b0100;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_all("ch0_fwait", 4'b0101, 4'b0000, 4'b0000, 4'b0101);
        end
        bus.clr = 4'b0001;
        tick();
        chk_all("ch0_fall_clr", 4'b0100, 4'b0000, 4'b0001, 4'b0101);
        bus.clr = 4'b0101;
        tick();
        chk_all("clr_both", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        bus.clr = 4'b0000;
        tick();
        chk_all("clr_hold", 4'b0100, 4'b0000, 4'b0000, 4'b0000);

        // All channels high: ch0,1,3 rise together, ch2 unaffected.
        bus.sig_nsyn = 4'b1111;
        for (int i = 1; i <= 6; i++) tick();
        chk_all("all_wait", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        tick();
        chk_all("all_rise", 4'b1111, 4'b1011, 4'b0000, 4'b1011);
        for (int i = 0; i < 3; i++) tick();
        chk_all("all_settled", 4'b1111, 4'b0000, 4'b0000, 4'b1011);

        // Single-edge reset with inputs held high; clr ignored under reset.
        rst = 1'b1;
        bus.clr = 4'b1111;
        tick();
        chk_all("rst_pulse", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        bus.clr = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_all("rst_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        tick();
        chk_all("rst_rise", 4'b1111, 4'b1111, 4'b0000, 4'b1111);
        tick();
        chk_all("rst_after", 4'b1111, 4'b0000, 4'b0000, 4'b1111);

        // Reset mid-filter on a falling transition: no fall pulse afterwards.
        bus.sig_nsyn = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        chk_all("mid_filter", 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_all("mid_rst_quiet", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
